// File: rtl/mcu_pkg.sv
// Shared definitions for the music player control path: FSM state encoding
// and the default song index width used by the MCU and the song reader.
package mcu_pkg;

    localparam int SONG_W_DEF = 2;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        PLAYING = 2'd1,
        NEXT    = 2'd2
    } state_t;

endpackage

// File: rtl/mcu.sv
// Master control unit: turns play/next button pulses and the player's song_done
// pulse into a play level, a one-cycle reset_player pulse and the song index.
module mcu
    import mcu_pkg::*;
#(
    parameter int SONG_W = SONG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              next_button,
    input  logic              song_done,
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] song
);

    localparam logic [SONG_W-1:0] SONG_ONE = {{(SONG_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic              play_nxt;
    logic              reset_player_nxt;
    logic [SONG_W-1:0] song_nxt;
    logic              advance;

    // next_button and song_done collapse into one advance request
    assign advance = next_button | song_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= PAUSED;
            play         <= 1'b0;
            reset_player <= 1'b0;
            song         <= '0;
        end else begin
            state        <= state_nxt;
            play         <= play_nxt;
            reset_player <= reset_player_nxt;
            song         <= song_nxt;
        end
    end

    // Outputs are computed for the state being entered so they appear registered.
    always_comb begin
        state_nxt        = state;
        play_nxt         = 1'b0;
        reset_player_nxt = 1'b0;
        song_nxt         = song;
        case (state)
            PAUSED: begin
                if (advance) begin
                    state_nxt        = NEXT;
                    song_nxt         = song + SONG_ONE;
                    reset_player_nxt = 1'b1;
                end else if (play_button) begin
                    state_nxt = PLAYING;
                    play_nxt  = 1'b1;
                end
            end
            PLAYING: begin
                if (advance) begin
                    state_nxt        = NEXT;
                    song_nxt         = song + SONG_ONE;
                    reset_player_nxt = 1'b1;
                end else if (play_button) begin
                    state_nxt = PAUSED;
                end else begin
                    play_nxt = 1'b1;
                end
            end
            NEXT: begin
                state_nxt = PAUSED;
            end
            default: begin
                state_nxt = PAUSED;
            end
        endcase
    end

endmodule

// File: tb/tb_mcu.sv
// Scoreboard bench for mcu: directed scenarios followed by random button traffic,
// checked against a behavioural player model.
module tb_mcu;

    localparam int SONG_W = 2;

    typedef struct packed {
        logic              play;
        logic              rp;
        logic [SONG_W-1:0] song;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              play_button;
    logic              next_button;
    logic              song_done;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];

    // behavioural model of the player as seen from outside
    bit m_playing;
    bit m_in_next;
    int m_song;

    mcu #(.SONG_W(SONG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .play_button  (play_button),
        .next_button  (next_button),
        .song_done    (song_done),
        .play         (play),
        .reset_player (reset_player),
        .song         (song)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_song(string name, logic [SONG_W-1:0] act, logic [SONG_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge and predict the outputs
    // that the following rising edge should produce.
    task automatic step(bit rst_n, bit pb, bit nb, bit sd);
        exp_t e;
        @(negedge clk);
        reset       = rst_n;
        play_button = pb;
        next_button = nb;
        song_done   = sd;
        if (!rst_n) begin
            #1;
            check_bit("async_reset_play", play, 1'b0);
            check_bit("async_reset_rp", reset_player, 1'b0);
            check_song("async_reset_song", song, '0);
            m_playing = 0;
            m_in_next = 0;
            m_song    = 0;
        end else if (m_in_next) begin
            m_in_next = 0;
            m_playing = 0;
        end else if (nb || sd) begin
            m_in_next = 1;
            m_playing = 0;
            m_song    = (m_song + 1) % (1 << SONG_W);
        end else if (pb) begin
            m_playing = !m_playing;
        end
        e.play = m_playing && !m_in_next;
        e.rp   = m_in_next;
        e.song = m_song[SONG_W-1:0];
        q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle, compared just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_bit("play", play, e.play);
                check_bit("reset_player", reset_player, e.rp);
                check_song("song", song, e.song);
            end
        end
    end

    initial begin
        int wait_cycles;
        reset       = 1'b0;
        play_button = 1'b0;
        next_button = 1'b0;
        song_done   = 1'b0;
        m_playing   = 0;
        m_in_next   = 0;
        m_song      = 0;

        // reset held two cycles then released
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        idle(2);

        // play toggles three times
        step(1, 1, 0, 0); idle(2);
        step(1, 1, 0, 0); idle(2);
        step(1, 1, 0, 0); idle(2);

        // next from PLAYING, then next pulses spaced three cycles, wrapping
        step(1, 0, 1, 0); idle(2);
        step(1, 0, 1, 0); idle(2);
        step(1, 0, 1, 0); idle(2);
        step(1, 0, 1, 0); idle(2);

        // song_done while playing, then resume on new song
        step(1, 1, 0, 0); idle(1);
        step(1, 0, 0, 1); idle(1);
        step(1, 1, 0, 0); idle(2);

        // play+next together, then next during the NEXT cycle is ignored
        step(1, 1, 1, 0);
        step(1, 0, 1, 0); idle(2);

        // next_button and song_done together advance once
        step(1, 0, 1, 1); idle(2);

        // reset reasserted mid-PLAYING
        step(1, 1, 0, 0); idle(2);
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        idle(2);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0));
        end
        idle(3);

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
